// File: rtl/keypad_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : keypad_pkg
//  Description : Shared constants and helpers for the 4x4 matrix keypad
//                scanner: FSM state encodings, column reset pattern, the
//                {row_idx, col_idx} -> hex key map and index encoders.
//  Revision    : 1.0 - initial release
// ============================================================================
package keypad_pkg;

    // FSM state encoding
    localparam logic [1:0] c_st_scan           = 2'd0;
    localparam logic [1:0] c_st_debounce_press = 2'd1;
    localparam logic [1:0] c_st_debounce_rel   = 2'd2;

    // Column 0 driven low after reset
    localparam logic [3:0] c_col_reset = 4'b1110;

    // Key map, 16 nibbles indexed by {row_idx, col_idx}; entry i lives in
    // bits [4*i +: 4]. Rows read (left to right, c0..c3):
    //   row0: 1 2 3 A   row1: 4 5 6 B   row2: 7 8 9 C   row3: 0 F E D
    localparam logic [63:0] c_key_map = 64'hDEF0_C987_B654_A321;

    // Index of the lowest active-low bit; lowest index wins when several
    // bits are low. An all-ones input maps to 3 but is never encoded.
    function automatic logic [1:0] low_index(input logic [3:0] vec_n);
        logic [1:0] idx;
        if (!vec_n[0])      idx = 2'd0;
        else if (!vec_n[1]) idx = 2'd1;
        else if (!vec_n[2]) idx = 2'd2;
        else                idx = 2'd3;
        return idx;
    endfunction

    function automatic logic [3:0] key_lookup(input logic [1:0] row_idx,
                                              input logic [1:0] col_idx);
        logic [5:0] bit_base;
        bit_base = {row_idx, col_idx, 2'b00};
        return c_key_map[bit_base +: 4];
    endfunction

endpackage
`default_nettype wire

// File: rtl/keypad_scanner_row_sync.sv
`default_nettype none
// ============================================================================
//  Module      : row_sync
//  Description : Two-flop synchronizer for asynchronous active-low inputs.
//                Resets to all-ones so that no row appears pressed while
//                the pipeline is being flushed.
//  Ports       : clk      - system clock
//                reset    - synchronous, active-low reset
//                i_async  - asynchronous input bus
//                o_sync   - synchronized output bus (2-cycle latency)
//  Revision    : 1.0 - initial release
// ============================================================================
module row_sync #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] i_async,
    output logic [WIDTH-1:0] o_sync
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_meta <= '1;
            r_sync <= '1;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
        end
    end

    assign o_sync = r_sync;

endmodule
`default_nettype wire

// File: rtl/keypad_scanner.sv
`default_nettype none
// ============================================================================
//  Module      : keypad_scanner
//  Description : 4x4 matrix keypad scanner. Drives one column low at a time,
//                samples synchronized rows at the end of each column dwell,
//                debounces press and release, and presents the key as a hex
//                code with a valid/ack handshake and a sticky overrun flag.
//  Ports       : clk         - system clock
//                reset       - synchronous, active-low reset
//                row         - keypad rows, active-low, asynchronous
//                col         - column drive, active-low one-hot
//                key_code    - hex value of the last accepted key
//                key_valid   - high from capture until acknowledged
//                key_ack     - consumer acknowledge
//                overrun     - sticky, new capture while key_valid was high
//                key_pressed - an accepted key is still held
//  Revision    : 1.0 - initial release
// ============================================================================
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int unsigned SCAN_W    = 17,
    parameter int unsigned DB_CYCLES = 1_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic [3:0] key_code,
    output logic       key_valid,
    input  logic       key_ack,
    output logic       overrun,
    output logic       key_pressed
);

    localparam int unsigned c_db_w = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [c_db_w-1:0] c_db_last = c_db_w'(DB_CYCLES - 1);

    logic [3:0]        w_rs;

    logic [1:0]        r_state;
    logic [SCAN_W-1:0] r_dwell;
    logic [c_db_w-1:0] r_db;
    logic [3:0]        r_pattern;
    logic [3:0]        r_col;
    logic [3:0]        r_key_code;
    logic              r_key_valid;
    logic              r_overrun;
    logic              r_key_pressed;

    logic [1:0]        w_state_d;
    logic [SCAN_W-1:0] w_dwell_d;
    logic [c_db_w-1:0] w_db_d;
    logic [3:0]        w_pattern_d;
    logic [3:0]        w_col_d;
    logic [3:0]        w_key_code_d;
    logic              w_key_valid_d;
    logic              w_overrun_d;
    logic [3:0]        w_col_next;

    row_sync #(
        .WIDTH (4)
    ) u_row_sync (
        .clk     (clk),
        .reset   (reset),
        .i_async (row),
        .o_sync  (w_rs)
    );

    // Rotating the zero left walks c0 -> c1 -> c2 -> c3 -> c0
    assign w_col_next = {r_col[2:0], r_col[3]};

    always_comb begin
        w_state_d     = r_state;
        w_dwell_d     = r_dwell;
        w_db_d        = r_db;
        w_pattern_d   = r_pattern;
        w_col_d       = r_col;
        w_key_code_d  = r_key_code;
        w_key_valid_d = r_key_valid;
        w_overrun_d   = r_overrun;

        // Acknowledge first; a capture in the same cycle overrides below
        if (key_ack && r_key_valid) begin
            w_key_valid_d = 1'b0;
            w_overrun_d   = 1'b0;
        end

        case (r_state)
            c_st_scan: begin
                // Wraps to zero naturally on the all-ones sample cycle
                w_dwell_d = r_dwell + 1'b1;
                if (&r_dwell) begin
                    if (w_rs != 4'hF) begin
                        w_pattern_d = w_rs;
                        w_db_d      = '0;
                        w_state_d   = c_st_debounce_press;
                    end else begin
                        w_col_d = w_col_next;
                    end
                end
            end

            c_st_debounce_press: begin
                if (w_rs != r_pattern) begin
                    // Bounce: resume scanning the same column from the top
                    w_state_d = c_st_scan;
                    w_dwell_d = '0;
                end else if (r_db == c_db_last) begin
                    w_key_code_d  = key_lookup(low_index(r_pattern),
                                               low_index(r_col));
                    w_key_valid_d = 1'b1;
                    w_overrun_d   = r_overrun | r_key_valid;
                    w_db_d        = '0;
                    w_state_d     = c_st_debounce_rel;
                end else begin
                    w_db_d = r_db + 1'b1;
                end
            end

            c_st_debounce_rel: begin
                if (w_rs == 4'hF) begin
                    if (r_db == c_db_last) begin
                        w_col_d   = w_col_next;
                        w_dwell_d = '0;
                        w_db_d    = '0;
                        w_state_d = c_st_scan;
                    end else begin
                        w_db_d = r_db + 1'b1;
                    end
                end else begin
                    w_db_d = '0;
                end
            end

            default: begin
                w_state_d = c_st_scan;
                w_dwell_d = '0;
                w_db_d    = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state       <= c_st_scan;
            r_dwell       <= '0;
            r_db          <= '0;
            r_pattern     <= 4'hF;
            r_col         <= c_col_reset;
            r_key_code    <= 4'h0;
            r_key_valid   <= 1'b0;
            r_overrun     <= 1'b0;
            r_key_pressed <= 1'b0;
        end else begin
            r_state       <= w_state_d;
            r_dwell       <= w_dwell_d;
            r_db          <= w_db_d;
            r_pattern     <= w_pattern_d;
            r_col         <= w_col_d;
            r_key_code    <= w_key_code_d;
            r_key_valid   <= w_key_valid_d;
            r_overrun     <= w_overrun_d;
            r_key_pressed <= (w_state_d == c_st_debounce_rel);
        end
    end

    assign col         = r_col;
    assign key_code    = r_key_code;
    assign key_valid   = r_key_valid;
    assign overrun     = r_overrun;
    assign key_pressed = r_key_pressed;

endmodule
`default_nettype wire

// File: tb/tb_keypad_scanner.sv
`default_nettype none
// ============================================================================
//  Module      : tb_keypad_scanner
//  Description : Self-checking bench for keypad_scanner with SCAN_W = 3 and
//                DB_CYCLES = 4. A keypad model pulls a row low whenever a
//                held key's column is driven; expected key codes are queued
//                at press time and popped on capture.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_keypad_scanner;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] row;
    logic [3:0] col;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_ack;
    logic       overrun;
    logic       key_pressed;

    logic [15:0] keys;          // held keys, index row*4 + col
    logic        row_force;
    logic [3:0]  row_force_val;

    logic [3:0]  exp_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;

    keypad_scanner #(
        .SCAN_W    (3),
        .DB_CYCLES (4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .row         (row),
        .col         (col),
        .key_code    (key_code),
        .key_valid   (key_valid),
        .key_ack     (key_ack),
        .overrun     (overrun),
        .key_pressed (key_pressed)
    );

    always #5 clk = ~clk;

    always_comb begin
        row = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (keys[r*4 + c] && !col[c]) row[r] = 1'b0;
        if (row_force) row = row_force_val;
    end

    function automatic logic [3:0] rot(input logic [3:0] c);
        return {c[2:0], c[3]};
    endfunction

    function automatic int col_idx(input logic [3:0] c);
        int idx;
        idx = 3;
        for (int i = 3; i >= 0; i--) if (!c[i]) idx = i;
        return idx;
    endfunction

    task automatic wait_pressed(input logic level, input int max, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max; i++) begin
            @(negedge clk);
            if (key_pressed === level) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_col_change(output logic [3:0] new_col, output bit ok);
        logic [3:0] start;
        start   = col;
        ok      = 1'b0;
        new_col = col;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (col !== start) begin
                ok      = 1'b1;
                new_col = col;
                break;
            end
        end
    endtask

    task automatic pulse_ack;
        key_ack = 1'b1;
        @(posedge clk);
        @(negedge clk);
        key_ack = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b0; key_ack = 1'b0; keys = '0;
        row_force = 1'b1; row_force_val = 4'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++; if (col !== 4'b1110) begin n_fail++; $display("FAIL reset_col actual=%b required=1110", col); end
        n_checks++; if (key_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid actual=%b required=0", key_valid); end
        n_checks++; if (key_code !== 4'h0) begin n_fail++; $display("FAIL reset_code actual=%h required=0", key_code); end
        n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL reset_overrun actual=%b required=0", overrun); end
        n_checks++; if (key_pressed !== 1'b0) begin n_fail++; $display("FAIL reset_pressed actual=%b required=0", key_pressed); end
        row_force = 1'b0;
        reset = 1'b1;
        repeat (7) @(posedge clk);
        @(negedge clk);
        n_checks++; if (col !== 4'b1110) begin n_fail++; $display("FAIL dwell_hold actual=%b required=1110", col); end
        @(posedge clk);
        @(negedge clk);
        n_checks++; if (col !== 4'b1101) begin n_fail++; $display("FAIL dwell_step actual=%b required=1101", col); end
    endtask

    task automatic test_press_5;
        bit ok;
        logic [3:0] exp;
        keys[5] = 1'b1;
        exp_q.push_back(4'h5);
        wait_pressed(1'b1, 200, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL press5_timeout actual=none required=capture"); end
        exp = exp_q.pop_front();
        n_checks++; if (key_code !== exp || key_valid !== 1'b1) begin n_fail++; $display("FAIL press5_code actual=%h/%b required=%h/1", key_code, key_valid, exp); end
        n_checks++; if (col !== 4'b1101) begin n_fail++; $display("FAIL press5_col actual=%b required=1101", col); end
        keys = '0;
        for (int k = 1; k <= 6; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (k == 5) begin
                n_checks++; if (key_pressed !== 1'b1) begin n_fail++; $display("FAIL rel_early actual=%b required=1", key_pressed); end
            end
        end
        n_checks++; if (key_pressed !== 1'b0 || col !== 4'b1011) begin n_fail++; $display("FAIL rel_done actual=%b/%b required=0/1011", key_pressed, col); end
        n_checks++; if (key_valid !== 1'b1 || key_code !== 4'h5) begin n_fail++; $display("FAIL rel_hold actual=%b/%h required=1/5", key_valid, key_code); end
        pulse_ack;
        n_checks++; if (key_valid !== 1'b0) begin n_fail++; $display("FAIL ack_clear actual=%b required=0", key_valid); end
        pulse_ack;
        n_checks++; if (key_valid !== 1'b0 || overrun !== 1'b0) begin n_fail++; $display("FAIL ack_idle actual=%b/%b required=0/0", key_valid, overrun); end
    endtask

    task automatic test_bounce;
        bit ok;
        bit bad;
        logic [3:0] cur;
        wait_col_change(cur, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL bounce_sync actual=stuck required=col_change"); end
        keys[4 + col_idx(cur)] = 1'b1;
        repeat (8) @(posedge clk);
        @(negedge clk);
        keys = '0;
        bad = 1'b0;
        for (int k = 9; k <= 19; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (key_valid !== 1'b0 || key_pressed !== 1'b0) bad = 1'b1;
            if (k == 18) begin
                n_checks++; if (col !== cur) begin n_fail++; $display("FAIL bounce_same_col actual=%b required=%b", col, cur); end
            end
        end
        n_checks++; if (bad) begin n_fail++; $display("FAIL bounce_valid actual=1 required=0"); end
        n_checks++; if (col !== rot(cur)) begin n_fail++; $display("FAIL bounce_advance actual=%b required=%b", col, rot(cur)); end
    endtask

    task automatic test_two_rows;
        bit ok;
        logic [3:0] exp;
        keys[3] = 1'b1; keys[15] = 1'b1;
        exp_q.push_back(4'hA);
        wait_pressed(1'b1, 200, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL two_rows_timeout actual=none required=capture"); end
        exp = exp_q.pop_front();
        n_checks++; if (key_code !== exp || col !== 4'b0111) begin n_fail++; $display("FAIL two_rows_code actual=%h/%b required=%h/0111", key_code, col, exp); end
        keys = '0;
        wait_pressed(1'b0, 50, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL two_rows_release actual=held required=released"); end
        pulse_ack;
    endtask

    task automatic test_overrun;
        bit ok;
        logic [3:0] exp;
        keys[0] = 1'b1;
        exp_q.push_back(4'h1);
        wait_pressed(1'b1, 200, ok);
        exp = exp_q.pop_front();
        n_checks++; if (!ok || key_code !== exp || overrun !== 1'b0) begin n_fail++; $display("FAIL ovr_first actual=%b/%h/%b required=1/%h/0", ok, key_code, overrun, exp); end
        keys = '0;
        wait_pressed(1'b0, 50, ok);
        keys[12] = 1'b1;
        exp_q.push_back(4'h0);
        wait_pressed(1'b1, 200, ok);
        exp = exp_q.pop_front();
        n_checks++; if (!ok || key_code !== exp) begin n_fail++; $display("FAIL ovr_code actual=%b/%h required=1/%h", ok, key_code, exp); end
        n_checks++; if (key_valid !== 1'b1 || overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_flag actual=%b/%b required=1/1", key_valid, overrun); end
        pulse_ack;
        n_checks++; if (key_valid !== 1'b0 || overrun !== 1'b0) begin n_fail++; $display("FAIL ovr_ack actual=%b/%b required=0/0", key_valid, overrun); end
        keys = '0;
        wait_pressed(1'b0, 50, ok);
    endtask

    task automatic test_reset_mid;
        bit ok;
        bit bad;
        logic [3:0] exp;
        logic [3:0] cur;
        keys[10] = 1'b1;
        exp_q.push_back(4'h9);
        wait_pressed(1'b1, 200, ok);
        exp = exp_q.pop_front();
        n_checks++; if (!ok || key_code !== exp) begin n_fail++; $display("FAIL mid_first actual=%b/%h required=1/%h", ok, key_code, exp); end
        keys = '0;
        wait_pressed(1'b0, 50, ok);
        wait_col_change(cur, ok);
        keys[8 + col_idx(cur)] = 1'b1;
        repeat (10) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        keys  = '0;
        @(posedge clk);
        @(negedge clk);
        n_checks++; if (col !== 4'b1110 || key_code !== 4'h0) begin n_fail++; $display("FAIL mid_reset_col_code actual=%b/%h required=1110/0", col, key_code); end
        n_checks++; if (key_valid !== 1'b0 || overrun !== 1'b0 || key_pressed !== 1'b0) begin n_fail++; $display("FAIL mid_reset_flags actual=%b/%b/%b required=0/0/0", key_valid, overrun, key_pressed); end
        reset = 1'b1;
        bad = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (key_valid !== 1'b0 || key_pressed !== 1'b0) bad = 1'b1;
        end
        n_checks++; if (bad || key_code !== 4'h0) begin n_fail++; $display("FAIL mid_no_capture actual=%b/%h required=0/0", bad, key_code); end
    endtask

    initial begin
        test_reset;
        test_press_5;
        test_bounce;
        test_two_rows;
        test_overrun;
        test_reset_mid;
        n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL scoreboard_drain actual=%0d required=0", exp_q.size()); end
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
